// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers sync timing, locks to the frame, and
// regenerates pixel coordinates, colour, a per-frame checksum and an error count.
module vga_rx_monitor #(
   parameter int CLKS_PER_PIX = 4,
   parameter int H_TOTAL      = 800,
   parameter int V_TOTAL      = 525,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        hSync,
   input  logic        vSync,
   input  logic        bright,
   input  logic [3:0]  vgaR,
   input  logic [3:0]  vgaG,
   input  logic [3:0]  vgaB,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        locked,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic        err_pulse,
   output logic [7:0]  err_count
);

   localparam int            PW       = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_PIX - 1);
   localparam logic [PW-1:0] PH_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] PH_ONE   = PW'(1);
   localparam logic [11:0]   LEN_EXP  = 12'(H_TOTAL * CLKS_PER_PIX - 1);
   localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]    V_TOT    = 10'(V_TOTAL);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic          hs_r, vs_r, br_r, hs_d_r, vs_d_r, br_d_r;
   logic [11:0]   rgb_r;
   logic [11:0]   len_r;
   logic          hs_seen_r;
   logic [PW-1:0] phase_r;
   logic [9:0]    sample_cnt_r, line_cnt_r, act_line_r;
   logic [15:0]   sum_acc_r;
   logic          frame_bad_r;
   state_t        state_r;

   logic          hs_fall_s, vs_fall_s, br_rise_s, sample_s, line_has_pix_s;
   logic          line_err_s, frame_err_s, err_s;
   logic [PW-1:0] phase_eff_s, phase_nxt_s;
   logic [9:0]    lines_s, acts_s;

   // Edge detection, pixel phase and per-line / per-frame timing checks.
   always_comb begin
      hs_fall_s      = hs_d_r & ~hs_r;
      vs_fall_s      = vs_d_r & ~vs_r;
      br_rise_s      = br_r & ~br_d_r;
      phase_eff_s    = br_rise_s ? PH_ZERO : phase_r;
      sample_s       = br_r && (phase_eff_s == PH_ZERO);
      phase_nxt_s    = (!br_r || (phase_eff_s == PH_LAST)) ? PH_ZERO : phase_eff_s + PH_ONE;
      line_has_pix_s = (sample_cnt_r != 10'd0);
      line_err_s     = hs_fall_s && ((hs_seen_r && (len_r != LEN_EXP)) ||
                                     (line_has_pix_s && (sample_cnt_r != H_ACT)));
      // A coincident hs_fall belongs to the frame that is ending.
      lines_s        = line_cnt_r + {9'd0, hs_fall_s};
      acts_s         = act_line_r + {9'd0, hs_fall_s & line_has_pix_s};
      frame_err_s    = vs_fall_s && ((lines_s != V_TOT) || (acts_s != V_ACT));
      err_s          = line_err_s | frame_err_s;
   end

   // Input register stage plus delayed copies for edge detection.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         hs_r   <= 1'b1;
         vs_r   <= 1'b1;
         br_r   <= 1'b0;
         rgb_r  <= 12'd0;
         hs_d_r <= 1'b1;
         vs_d_r <= 1'b1;
         br_d_r <= 1'b0;
      end else begin
         hs_r   <= hSync;
         vs_r   <= vSync;
         br_r   <= bright;
         rgb_r  <= {vgaR, vgaG, vgaB};
         hs_d_r <= hs_r;
         vs_d_r <= vs_r;
         br_d_r <= br_r;
      end
   end

   // Line length, pixel phase, sample and line counters.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         len_r        <= 12'd0;
         hs_seen_r    <= 1'b0;
         phase_r      <= PH_ZERO;
         sample_cnt_r <= 10'd0;
         line_cnt_r   <= 10'd0;
         act_line_r   <= 10'd0;
      end else begin
         phase_r <= phase_nxt_s;
         if (hs_fall_s) begin
            len_r        <= 12'd0;
            hs_seen_r    <= 1'b1;
            sample_cnt_r <= 10'd0;
         end else begin
            if (len_r != 12'hFFF) begin
               len_r <= len_r + 12'd1;
            end
            if (sample_s) begin
               sample_cnt_r <= sample_cnt_r + 10'd1;
            end
         end
         if (vs_fall_s) begin
            line_cnt_r <= 10'd0;
            act_line_r <= 10'd0;
         end else if (hs_fall_s) begin
            line_cnt_r <= line_cnt_r + 10'd1;
            act_line_r <= acts_s;
         end
      end
   end

   // Frame colour checksum, published at every vs_fall outside SEARCH.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         sum_acc_r <= 16'd0;
         frame_sum <= 16'd0;
      end else if (vs_fall_s) begin
         sum_acc_r <= sample_s ? {4'b0000, rgb_r} : 16'd0;
         if (state_r != SEARCH) begin
            frame_sum <= sum_acc_r;
         end
      end else if (sample_s) begin
         sum_acc_r <= sum_acc_r + {4'b0000, rgb_r};
      end
   end

   // Lock state machine with its registered status and error outputs.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         state_r     <= SEARCH;
         locked      <= 1'b0;
         frame_done  <= 1'b0;
         err_pulse   <= 1'b0;
         err_count   <= 8'd0;
         frame_bad_r <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err_pulse  <= 1'b0;
         case (state_r)
            SEARCH: begin
               if (vs_fall_s) begin
                  state_r <= MEASURE;
               end
            end
            MEASURE: begin
               if (err_s) begin
                  state_r <= SEARCH;
               end else if (vs_fall_s) begin
                  state_r <= LOCKED;
                  locked  <= 1'b1;
               end
            end
            LOCKED: begin
               if (err_s) begin
                  err_pulse <= 1'b1;
                  err_count <= sat_inc8(err_count);
               end
               if (vs_fall_s) begin
                  frame_done <= !frame_bad_r && !err_s;
                  if (frame_bad_r || err_s) begin
                     state_r <= MEASURE;
                     locked  <= 1'b0;
                  end
               end else if (line_err_s) begin
                  frame_bad_r <= 1'b1;
               end
            end
            default: begin
               state_r <= SEARCH;
               locked  <= 1'b0;
            end
         endcase
         if (vs_fall_s) begin
            frame_bad_r <= 1'b0;
         end
      end
   end

   // Registered pixel strobe with coordinates and colour.
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         pix_valid <= 1'b0;
         pix_x     <= 10'd0;
         pix_y     <= 10'd0;
         pix_rgb   <= 12'd0;
      end else begin
         pix_valid <= sample_s && (state_r == LOCKED);
         if (sample_s && (state_r == LOCKED)) begin
            pix_x   <= sample_cnt_r;
            pix_y   <= act_line_r;
            pix_rgb <= rgb_r;
         end
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken 8x6-pixel frame (5x4 visible,
// 2 clocks per pixel) so that hundreds of frames fit in a short run.
module tb_vga_rx_monitor;
   localparam int CPP = 2;
   localparam int HT  = 8;
   localparam int HA  = 5;
   localparam int VT  = 6;
   localparam int VA  = 4;

   logic        ClkPort = 1'b0;
   logic        Reset   = 1'b1;
   logic        hSync   = 1'b1;
   logic        vSync   = 1'b1;
   logic        bright  = 1'b0;
   logic [3:0]  vgaR = 4'd0, vgaG = 4'd0, vgaB = 4'd0;
   logic        pix_valid, locked, frame_done, err_pulse;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pix_rgb;
   logic [15:0] frame_sum;
   logic [7:0]  err_count;

   int   n_vec = 0, n_miss = 0;
   int   cyc = 0, n_valid, n_err, n_done, err_cyc, done_cyc, lock_cyc, exp_err_cyc, grad_bad;
   bit   prev_valid = 1'b0, prev_locked = 1'b0, consec, lock_ever;
   logic [9:0]  ex, ey;
   int   vsq[$];
   logic        snap_pre_locked, snap_locked, snap_valid;
   logic [15:0] snap_pre_sum, snap_sum;

   vga_rx_monitor #(
      .CLKS_PER_PIX(CPP), .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)
   ) dut (
      .ClkPort(ClkPort), .Reset(Reset), .hSync(hSync), .vSync(vSync), .bright(bright),
      .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB), .pix_valid(pix_valid), .pix_x(pix_x),
      .pix_y(pix_y), .pix_rgb(pix_rgb), .locked(locked), .frame_done(frame_done),
      .frame_sum(frame_sum), .err_pulse(err_pulse), .err_count(err_count)
   );

   always #5 ClkPort = ~ClkPort;

   // One clock: observe outputs just after the edge, then drive the next inputs.
   task automatic step(input logic hs, input logic vs, input logic br, input logic [11:0] rgb);
      @(posedge ClkPort);
      #1;
      cyc++;
      if (pix_valid) begin
         n_valid++;
         if (prev_valid) consec = 1'b1;
         if (pix_x !== ex || pix_y !== ey || pix_rgb !== {ex[3:0], ey[3:0], 4'h0}) grad_bad++;
         if (ex == 10'(HA - 1)) begin
            ex = 10'd0;
            ey = ey + 10'd1;
         end else begin
            ex = ex + 10'd1;
         end
      end
      if (err_pulse) begin n_err++; err_cyc = cyc; end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      if (locked && !prev_locked) lock_cyc = cyc;
      if (locked) lock_ever = 1'b1;
      prev_valid  = pix_valid;
      prev_locked = locked;
      if (vSync && !vs) vsq.push_back(cyc);
      hSync  = hs;
      vSync  = vs;
      bright = br;
      {vgaR, vgaG, vgaB} = rgb;
   endtask

   task automatic drive_frame(input bit grad, input bit br_en, input int stretch_line, input int rst_line);
      for (int l = 0; l < VT; l++) begin
         for (int p = 0; p < HT + ((l == stretch_line) ? 1 : 0); p++) begin
            for (int c = 0; c < CPP; c++) begin
               logic        br;
               logic [11:0] rgb;
               br  = br_en && (l < VA) && (p < HA);
               rgb = !br ? 12'h000 : (grad ? {4'(p), 4'(l), 4'h0} : 12'h001);
               step(p != HT - 2, l != VT - 1, br, rgb);
               if (l == stretch_line + 1 && p == HT - 2 && c == 0) exp_err_cyc = cyc + 2;
               if (l == rst_line && p == 0 && c == 0) begin
                  snap_pre_locked = locked;
                  snap_pre_sum    = frame_sum;
                  #1 Reset = 1'b1;
                  #1;
                  snap_locked = locked;
                  snap_sum    = frame_sum;
                  snap_valid  = pix_valid;
                  #1 Reset = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic clear_counts();
      n_valid = 0; n_err = 0; n_done = 0; grad_bad = 0;
      err_cyc = -1; done_cyc = -1; lock_cyc = -1; exp_err_cyc = -2;
      consec = 1'b0; lock_ever = 1'b0; ex = 10'd0; ey = 10'd0;
      vsq.delete();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) step(1'b1, 1'b1, 1'b0, 12'h000);
      n_vec++; if (pix_valid !== 1'b0) begin n_miss++; $display("FAIL reset_pix_valid: got %0h want 0", pix_valid); end
      n_vec++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin n_miss++; $display("FAIL reset_xy: got %0d,%0d want 0,0", pix_x, pix_y); end
      n_vec++; if (pix_rgb !== 12'd0) begin n_miss++; $display("FAIL reset_rgb: got %h want 000", pix_rgb); end
      n_vec++; if (locked !== 1'b0 || frame_done !== 1'b0) begin n_miss++; $display("FAIL reset_lock_done: got %b%b want 00", locked, frame_done); end
      n_vec++; if (frame_sum !== 16'd0) begin n_miss++; $display("FAIL reset_sum: got %h want 0000", frame_sum); end
      n_vec++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin n_miss++; $display("FAIL reset_err: got %b/%0d want 0/0", err_pulse, err_count); end
      Reset = 1'b0;
      repeat (2) step(1'b1, 1'b1, 1'b0, 12'h000);
   endtask

   task automatic test_nominal();
      clear_counts();
      repeat (4) drive_frame(1'b0, 1'b1, -1, -1);
      n_vec++; if (lock_cyc !== vsq[1] + 2) begin n_miss++; $display("FAIL nom_lock_time: got %0d want %0d", lock_cyc, vsq[1] + 2); end
      n_vec++; if (n_done !== 2) begin n_miss++; $display("FAIL nom_done_count: got %0d want 2", n_done); end
      n_vec++; if (done_cyc !== vsq[3] + 2) begin n_miss++; $display("FAIL nom_done_time: got %0d want %0d", done_cyc, vsq[3] + 2); end
      n_vec++; if (frame_sum !== 16'h0014) begin n_miss++; $display("FAIL nom_sum: got %h want 0014", frame_sum); end
      n_vec++; if (n_err !== 0 || err_count !== 8'd0) begin n_miss++; $display("FAIL nom_err: got %0d/%0d want 0/0", n_err, err_count); end
      n_vec++; if (n_valid !== 2 * HA * VA) begin n_miss++; $display("FAIL nom_valid_count: got %0d want %0d", n_valid, 2 * HA * VA); end
      n_vec++; if (consec !== 1'b0) begin n_miss++; $display("FAIL nom_consec_valid: got %b want 0", consec); end
      n_vec++; if (locked !== 1'b1) begin n_miss++; $display("FAIL nom_locked: got %b want 1", locked); end
   endtask

   task automatic test_gradient();
      clear_counts();
      drive_frame(1'b1, 1'b1, -1, -1);
      n_vec++; if (n_valid !== HA * VA) begin n_miss++; $display("FAIL grad_count: got %0d want %0d", n_valid, HA * VA); end
      n_vec++; if (grad_bad !== 0) begin n_miss++; $display("FAIL grad_pixels: got %0d bad want 0", grad_bad); end
      n_vec++; if (frame_sum !== 16'h29E0) begin n_miss++; $display("FAIL grad_sum: got %h want 29e0", frame_sum); end
      n_vec++; if (n_done !== 1) begin n_miss++; $display("FAIL grad_done: got %0d want 1", n_done); end
      n_vec++; if (pix_x !== 10'd4 || pix_y !== 10'd3 || pix_rgb !== 12'h430) begin n_miss++; $display("FAIL grad_last: got %0d,%0d,%h want 4,3,430", pix_x, pix_y, pix_rgb); end
   endtask

   task automatic test_stretch();
      clear_counts();
      drive_frame(1'b0, 1'b1, 1, -1);
      n_vec++; if (n_err !== 1) begin n_miss++; $display("FAIL str_err_pulses: got %0d want 1", n_err); end
      n_vec++; if (err_cyc !== exp_err_cyc) begin n_miss++; $display("FAIL str_err_time: got %0d want %0d", err_cyc, exp_err_cyc); end
      n_vec++; if (err_count !== 8'd1) begin n_miss++; $display("FAIL str_err_count: got %0d want 1", err_count); end
      n_vec++; if (n_done !== 0) begin n_miss++; $display("FAIL str_no_done: got %0d want 0", n_done); end
      n_vec++; if (locked !== 1'b0) begin n_miss++; $display("FAIL str_unlock: got %b want 0", locked); end
      drive_frame(1'b0, 1'b1, -1, -1);
      n_vec++; if (locked !== 1'b1 || n_done !== 0) begin n_miss++; $display("FAIL str_relock: got %b/%0d want 1/0", locked, n_done); end
      drive_frame(1'b0, 1'b1, -1, -1);
      n_vec++; if (n_done !== 1) begin n_miss++; $display("FAIL str_done_after: got %0d want 1", n_done); end
   endtask

   task automatic test_no_bright();
      Reset = 1'b1;
      repeat (3) step(1'b1, 1'b1, 1'b0, 12'h000);
      Reset = 1'b0;
      clear_counts();
      repeat (3) drive_frame(1'b0, 1'b0, -1, -1);
      n_vec++; if (lock_ever !== 1'b0) begin n_miss++; $display("FAIL nb_lock: got %b want 0", lock_ever); end
      n_vec++; if (n_err !== 0 || err_count !== 8'd0) begin n_miss++; $display("FAIL nb_err: got %0d/%0d want 0/0", n_err, err_count); end
      n_vec++; if (n_valid !== 0 || n_done !== 0) begin n_miss++; $display("FAIL nb_valid_done: got %0d/%0d want 0/0", n_valid, n_done); end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      repeat (2) drive_frame(1'b0, 1'b1, -1, -1);
      vsq.delete();
      lock_cyc = -1;
      drive_frame(1'b0, 1'b1, -1, 2);
      n_vec++; if (snap_pre_locked !== 1'b1 || snap_pre_sum !== 16'h0014) begin n_miss++; $display("FAIL rm_before: got %b/%h want 1/0014", snap_pre_locked, snap_pre_sum); end
      n_vec++; if (snap_locked !== 1'b0 || snap_sum !== 16'd0 || snap_valid !== 1'b0) begin n_miss++; $display("FAIL rm_async_clear: got %b/%h/%b want 0/0000/0", snap_locked, snap_sum, snap_valid); end
      n_vec++; if (locked !== 1'b0) begin n_miss++; $display("FAIL rm_not_locked: got %b want 0", locked); end
      drive_frame(1'b0, 1'b1, -1, -1);
      n_vec++; if (lock_cyc !== vsq[1] + 2) begin n_miss++; $display("FAIL rm_relock_time: got %0d want %0d", lock_cyc, vsq[1] + 2); end
   endtask

   task automatic test_saturate();
      clear_counts();
      repeat (300) begin
         drive_frame(1'b0, 1'b1, 1, -1);
         drive_frame(1'b0, 1'b1, -1, -1);
      end
      n_vec++; if (n_err !== 300) begin n_miss++; $display("FAIL sat_pulses: got %0d want 300", n_err); end
      n_vec++; if (err_count !== 8'd255) begin n_miss++; $display("FAIL sat_count: got %0d want 255", err_count); end
      n_vec++; if (locked !== 1'b1) begin n_miss++; $display("FAIL sat_locked: got %b want 1", locked); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_gradient();
      test_stretch();
      test_no_bright();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
